// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution front-end.
//   BitLenDef / MLenDef / ConvLenDef : default element, window and result widths
//   feeder_state_e                   : window feeder FSM encoding
//   slot_add                         : modulo-3 arithmetic on line-buffer slot indices
package conv_pkg;

    localparam int unsigned BitLenDef  = 8;
    localparam int unsigned MLenDef    = 3;
    localparam int unsigned ConvLenDef = 20;

    typedef enum logic [2:0] {
        StIdle,
        StLoadK,
        StFill,
        StEmit,
        StWait,
        StOut
    } feeder_state_e;

    // (slot + n) mod 3, with slot in 0..2 and n in 0..3.
    function automatic logic [1:0] slot_add(input logic [1:0] slot, input logic [1:0] n);
        logic [2:0] s;
        s = {1'b0, slot} + {1'b0, n};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Circular store of M_LEN image rows, each IMG_W pixels of BIT_LEN bits.
//   i_clk      : rising-edge clock
//   i_wr_en    : write strobe
//   i_wr_slot  : row slot written (0..M_LEN-1)
//   i_wr_col   : column written
//   i_wr_data  : pixel written
//   i_rd_slot  : row slot read
//   i_rd_col   : leftmost column of the read window
//   o_rd_data  : M_LEN adjacent pixels, column i_rd_col+k in bits [(k+1)*BIT_LEN-1 -: BIT_LEN]
// Read is combinational; storage has no reset because the feeder's counters
// define which entries hold valid data.
module conv_line_buffer #(
    parameter int unsigned BIT_LEN = 8,
    parameter int unsigned M_LEN   = 3,
    parameter int unsigned IMG_W   = 8,
    localparam int unsigned ColW   = $clog2(IMG_W),
    localparam int unsigned SlotW  = $clog2(M_LEN)
) (
    input  logic                       i_clk,
    input  logic                       i_wr_en,
    input  logic [SlotW-1:0]           i_wr_slot,
    input  logic [ColW-1:0]            i_wr_col,
    input  logic [BIT_LEN-1:0]         i_wr_data,
    input  logic [SlotW-1:0]           i_rd_slot,
    input  logic [ColW-1:0]            i_rd_col,
    output logic [BIT_LEN*M_LEN-1:0]   o_rd_data
);

    logic [BIT_LEN-1:0] mem_q [M_LEN][IMG_W];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_slot][i_wr_col] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < int'(M_LEN); k++) begin
            // Columns past the row end read as zero; the feeder never asks for them.
            if (int'(i_rd_col) + k < int'(IMG_W)) begin
                o_rd_data[k*BIT_LEN +: BIT_LEN] = mem_q[i_rd_slot][ColW'(int'(i_rd_col) + k)];
            end
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Front-end sequencer for the 3x3 convolution engine.
// Loads three kernel rows, buffers the raster pixel stream in a 3-row circular
// line buffer, shifts each valid 3x3 window into the engine row by row, captures
// the engine result and presents it on a valid/ready stream in raster order.
//   i_clk / i_reset_n            : clock, synchronous active-low reset
//   i_start                      : start a frame (only honoured when idle)
//   i_k_valid/i_k_data/o_k_ready : kernel rows, top first, col0 in LSBs
//   i_px_valid/i_px_data/o_px_ready : pixels in raster order
//   o_selec_K/o_data_kernel      : engine kernel row shift port (registered)
//   o_selec_I/o_data_img         : engine image row shift port (registered)
//   i_conv_data                  : engine result
//   o_res_valid/o_res_data/o_res_last/i_res_ready : result stream
//   o_busy                       : high whenever a frame is in progress
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int unsigned BIT_LEN  = BitLenDef,
    parameter int unsigned M_LEN    = MLenDef,
    parameter int unsigned CONV_LEN = ConvLenDef,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_k_valid,
    input  logic [BIT_LEN*M_LEN-1:0]  i_k_data,
    output logic                      o_k_ready,
    input  logic                      i_px_valid,
    input  logic [BIT_LEN-1:0]        i_px_data,
    output logic                      o_px_ready,
    output logic                      o_selec_K,
    output logic [BIT_LEN*M_LEN-1:0]  o_data_kernel,
    output logic                      o_selec_I,
    output logic [BIT_LEN*M_LEN-1:0]  o_data_img,
    input  logic [CONV_LEN-1:0]       i_conv_data,
    output logic                      o_res_valid,
    output logic [CONV_LEN-1:0]       o_res_data,
    output logic                      o_res_last,
    input  logic                      i_res_ready,
    output logic                      o_busy
);

    localparam int unsigned ColW    = $clog2(IMG_W);
    localparam int unsigned RowW    = $clog2(IMG_H);
    localparam int unsigned SlotW   = $clog2(M_LEN);
    localparam int unsigned RowBits = BIT_LEN * M_LEN;

    localparam logic [ColW-1:0] LastCol     = ColW'(IMG_W - 1);
    localparam logic [ColW-1:0] LastWinCol  = ColW'(IMG_W - M_LEN);
    localparam logic [RowW-1:0] LastRow     = RowW'(IMG_H - 1);
    localparam logic [RowW-1:0] FirstWinRow = RowW'(M_LEN - 1);

    feeder_state_e state_q, state_d;

    logic [1:0]          k_cnt_q, k_cnt_d;
    logic [ColW-1:0]     wr_col_q, wr_col_d;
    // Row currently being filled; during EMIT/WAIT/OUT it is the window's bottom row.
    logic [RowW-1:0]     row_q, row_d;
    // Line-buffer slot holding row_q.
    logic [SlotW-1:0]    slot_q, slot_d;
    logic [ColW-1:0]     win_col_q, win_col_d;
    logic [1:0]          emit_idx_q, emit_idx_d;
    logic                wait_q, wait_d;

    logic                selec_k_q, selec_k_d;
    logic [RowBits-1:0]  data_kernel_q, data_kernel_d;
    logic                selec_i_q, selec_i_d;
    logic [RowBits-1:0]  data_img_q, data_img_d;
    logic                res_valid_q, res_valid_d;
    logic [CONV_LEN-1:0] res_data_q, res_data_d;
    logic                res_last_q, res_last_d;

    logic                k_fire;
    logic                px_fire;
    logic                res_fire;
    logic                lb_we;
    logic [SlotW-1:0]    rd_slot;
    logic [RowBits-1:0]  lb_rd_data;

    assign k_fire   = i_k_valid & (state_q == StLoadK);
    assign px_fire  = i_px_valid & (state_q == StFill);
    assign res_fire = res_valid_q & i_res_ready;

    conv_line_buffer #(
        .BIT_LEN (BIT_LEN),
        .M_LEN   (M_LEN),
        .IMG_W   (IMG_W)
    ) u_line_buffer (
        .i_clk     (i_clk),
        .i_wr_en   (lb_we),
        .i_wr_slot (slot_q),
        .i_wr_col  (wr_col_q),
        .i_wr_data (i_px_data),
        .i_rd_slot (rd_slot),
        .i_rd_col  (win_col_d),
        .o_rd_data (lb_rd_data)
    );

    always_comb begin
        state_d       = state_q;
        k_cnt_d       = k_cnt_q;
        wr_col_d      = wr_col_q;
        row_d         = row_q;
        slot_d        = slot_q;
        win_col_d     = win_col_q;
        emit_idx_d    = emit_idx_q;
        wait_d        = wait_q;
        selec_k_d     = 1'b0;
        data_kernel_d = data_kernel_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_last_d    = res_last_q;
        lb_we         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StLoadK;
                    k_cnt_d   = 2'd0;
                    wr_col_d  = '0;
                    row_d     = '0;
                    slot_d    = '0;
                    win_col_d = '0;
                end
            end
            StLoadK: begin
                if (k_fire) begin
                    selec_k_d     = 1'b1;
                    data_kernel_d = i_k_data;
                    if (k_cnt_q == 2'd2) begin
                        state_d = StFill;
                    end else begin
                        k_cnt_d = k_cnt_q + 2'd1;
                    end
                end
            end
            StFill: begin
                if (px_fire) begin
                    lb_we = 1'b1;
                    if (wr_col_q == LastCol) begin
                        wr_col_d = '0;
                        if (row_q >= FirstWinRow) begin
                            state_d    = StEmit;
                            win_col_d  = '0;
                            emit_idx_d = 2'd0;
                        end else begin
                            row_d  = row_q + 1'b1;
                            slot_d = slot_add(slot_q, 2'd1);
                        end
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            StEmit: begin
                if (emit_idx_q == 2'd2) begin
                    state_d = StWait;
                    wait_d  = 1'b0;
                end else begin
                    emit_idx_d = emit_idx_q + 2'd1;
                end
            end
            StWait: begin
                // Engine needs one cycle for its product register and one for the
                // combinational sum before the result is safe to sample.
                if (wait_q) begin
                    state_d     = StOut;
                    res_valid_d = 1'b1;
                    res_data_d  = i_conv_data;
                    res_last_d  = (row_q == LastRow) && (win_col_q == LastWinCol);
                end else begin
                    wait_d = 1'b1;
                end
            end
            StOut: begin
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (win_col_q == LastWinCol) begin
                        if (row_q == LastRow) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StFill;
                            row_d   = row_q + 1'b1;
                            slot_d  = slot_add(slot_q, 2'd1);
                        end
                    end else begin
                        state_d    = StEmit;
                        win_col_d  = win_col_q + 1'b1;
                        emit_idx_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Image strobe/data are computed from next-state so the registered outputs
        // line up exactly with the EMIT cycles. Emit index 0 is the top row
        // (two rows above row_q), index 2 the bottom row.
        selec_i_d  = (state_d == StEmit);
        rd_slot    = slot_add(slot_q, emit_idx_d + 2'd1);
        data_img_d = selec_i_d ? lb_rd_data : data_img_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= StIdle;
            k_cnt_q       <= 2'd0;
            wr_col_q      <= '0;
            row_q         <= '0;
            slot_q        <= '0;
            win_col_q     <= '0;
            emit_idx_q    <= 2'd0;
            wait_q        <= 1'b0;
            selec_k_q     <= 1'b0;
            data_kernel_q <= '0;
            selec_i_q     <= 1'b0;
            data_img_q    <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_cnt_q       <= k_cnt_d;
            wr_col_q      <= wr_col_d;
            row_q         <= row_d;
            slot_q        <= slot_d;
            win_col_q     <= win_col_d;
            emit_idx_q    <= emit_idx_d;
            wait_q        <= wait_d;
            selec_k_q     <= selec_k_d;
            data_kernel_q <= data_kernel_d;
            selec_i_q     <= selec_i_d;
            data_img_q    <= data_img_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_last_q    <= res_last_d;
        end
    end

    assign o_k_ready     = (state_q == StLoadK);
    assign o_px_ready    = (state_q == StFill);
    assign o_busy        = (state_q != StIdle);
    assign o_selec_K     = selec_k_q;
    assign o_data_kernel = data_kernel_q;
    assign o_selec_I     = selec_i_q;
    assign o_data_img    = data_img_q;
    assign o_res_valid   = res_valid_q;
    assign o_res_data    = res_data_q;
    assign o_res_last    = res_last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder with a behavioural 3x3 engine: row-shift load
// registers, one product register stage, combinational signed sum.
module tb_conv_window_feeder;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic        i_k_valid;
    logic [23:0] i_k_data;
    logic        o_k_ready;
    logic        i_px_valid;
    logic [7:0]  i_px_data;
    logic        o_px_ready;
    logic        o_selec_K;
    logic [23:0] o_data_kernel;
    logic        o_selec_I;
    logic [23:0] o_data_img;
    logic [19:0] conv_data;
    logic        o_res_valid;
    logic [19:0] o_res_data;
    logic        o_res_last;
    logic        i_res_ready;
    logic        o_busy;

    int tests = 0;
    int fails = 0;
    int selk_cnt = 0;
    int seli_cnt = 0;

    always #5 clk = ~clk;

    conv_window_feeder #(
        .BIT_LEN  (8),
        .M_LEN    (3),
        .CONV_LEN (20),
        .IMG_W    (8),
        .IMG_H    (8)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_k_valid     (i_k_valid),
        .i_k_data      (i_k_data),
        .o_k_ready     (o_k_ready),
        .i_px_valid    (i_px_valid),
        .i_px_data     (i_px_data),
        .o_px_ready    (o_px_ready),
        .o_selec_K     (o_selec_K),
        .o_data_kernel (o_data_kernel),
        .o_selec_I     (o_selec_I),
        .o_data_img    (o_data_img),
        .i_conv_data   (conv_data),
        .o_res_valid   (o_res_valid),
        .o_res_data    (o_res_data),
        .o_res_last    (o_res_last),
        .i_res_ready   (i_res_ready),
        .o_busy        (o_busy)
    );

    // Behavioural engine: index 0 is the top row after three shifts.
    logic signed [7:0]  ek   [3][3];
    logic signed [7:0]  ei   [3][3];
    logic signed [15:0] prod [3][3];

    always @(posedge clk) begin
        if (o_selec_K) selk_cnt <= selk_cnt + 1;
        if (o_selec_I) seli_cnt <= seli_cnt + 1;
        for (int j = 0; j < 3; j++) begin
            if (o_selec_K) begin
                ek[0][j] <= ek[1][j];
                ek[1][j] <= ek[2][j];
                ek[2][j] <= o_data_kernel[j*8 +: 8];
            end
            if (o_selec_I) begin
                ei[0][j] <= ei[1][j];
                ei[1][j] <= ei[2][j];
                ei[2][j] <= o_data_img[j*8 +: 8];
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                prod[i][j] <= ek[i][j] * ei[i][j];
            end
        end
    end

    always_comb begin
        conv_data = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                conv_data = conv_data + {{4{prod[i][j][15]}}, prod[i][j]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_k_ready"},  32'(o_k_ready),     32'h0);
        check({pfx, "_px_ready"}, 32'(o_px_ready),    32'h0);
        check({pfx, "_selec_K"},  32'(o_selec_K),     32'h0);
        check({pfx, "_data_k"},   32'(o_data_kernel), 32'h0);
        check({pfx, "_selec_I"},  32'(o_selec_I),     32'h0);
        check({pfx, "_data_img"}, 32'(o_data_img),    32'h0);
        check({pfx, "_res_vld"},  32'(o_res_valid),   32'h0);
        check({pfx, "_res_data"}, 32'(o_res_data),    32'h0);
        check({pfx, "_res_last"}, 32'(o_res_last),    32'h0);
        check({pfx, "_busy"},     32'(o_busy),        32'h0);
    endtask

    // Modes: 0 ones/ones, 1 centre tap on row*8+col, 2 top row {1,2,3} on col index,
    // 3 all -1 kernel on ones.
    function automatic logic [23:0] krow(input int mode, input int ki);
        case (mode)
            0:       return 24'h010101;
            1:       return (ki == 1) ? 24'h000100 : 24'h000000;
            2:       return (ki == 0) ? 24'h030201 : 24'h000000;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [7:0] pix(input int mode, input int pi);
        case (mode)
            1:       return 8'(pi);
            2:       return 8'(pi % 8);
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] exp_res(input int mode, input int ri);
        int r;
        int c;
        r = ri / 6;
        c = ri % 6;
        case (mode)
            0:       return 32'd9;
            1:       return 32'((r + 1) * 8 + c + 1);
            2:       return 32'(6 * c + 8);
            default: return 32'h000FFFF7;
        endcase
    endfunction

    task automatic run_frame(input string name, input int mode, input bit rnd_ready,
                             input bit px_gaps, input bit abort_mid, input bit start_in_fill);
        int ki;
        int pi;
        int ri;
        int sk0;
        int si0;
        bit done;
        bit holding;
        logic [31:0] hold_data;
        logic hold_last;
        ki = 0;
        pi = 0;
        ri = 0;
        done = 1'b0;
        holding = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        sk0 = selk_cnt;
        si0 = seli_cnt;
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            @(negedge clk);
            if (holding) begin
                check({name, "_hold_vld"},  32'(o_res_valid), 32'h1);
                check({name, "_hold_data"}, 32'(o_res_data),  hold_data);
                check({name, "_hold_last"}, 32'(o_res_last),  32'(hold_last));
            end
            if (abort_mid && ri == 12 && o_selec_I) begin
                i_reset_n   = 1'b0;
                i_start     = 1'b0;
                i_k_valid   = 1'b0;
                i_px_valid  = 1'b0;
                i_res_ready = 1'b0;
                @(negedge clk);
                check_zero({name, "_abort"});
                i_reset_n = 1'b1;
                return;
            end
            i_start     = (cyc == 0) || (start_in_fill && pi == 20 && o_px_ready);
            i_k_valid   = (ki < 3);
            i_k_data    = krow(mode, ki);
            i_px_valid  = (pi < 64) && (!px_gaps || $urandom_range(0, 2) != 0);
            i_px_data   = pix(mode, pi);
            i_res_ready = !rnd_ready || ($urandom_range(0, 1) == 1);
            if (i_k_valid && o_k_ready) ki++;
            if (i_px_valid && o_px_ready) pi++;
            holding = 1'b0;
            if (o_res_valid) begin
                if (i_res_ready) begin
                    check({name, "_res"},  32'(o_res_data), exp_res(mode, ri));
                    check({name, "_last"}, 32'(o_res_last), 32'(ri == 35));
                    ri++;
                    if (ri == 36) done = 1'b1;
                end else begin
                    holding   = 1'b1;
                    hold_data = 32'(o_res_data);
                    hold_last = o_res_last;
                end
            end
        end
        @(negedge clk);
        i_start     = 1'b0;
        i_k_valid   = 1'b0;
        i_px_valid  = 1'b0;
        i_res_ready = 1'b0;
        check({name, "_count"},   32'(ri),             32'd36);
        check({name, "_busy"},    32'(o_busy),         32'h0);
        check({name, "_nselK"},   32'(selk_cnt - sk0), 32'd3);
        check({name, "_nselI"},   32'(seli_cnt - si0), 32'd108);
        check({name, "_vld_off"}, 32'(o_res_valid),    32'h0);
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_start     = 1'b0;
        i_k_valid   = 1'b0;
        i_k_data    = '0;
        i_px_valid  = 1'b0;
        i_px_data   = '0;
        i_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        i_reset_n = 1'b1;

        run_frame("t1_ones",   0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("t2_centre", 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("t3_cols",   2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("t4_stall",  1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("t5_abort",  0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("t5_after",  0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("t6_neg",    3, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (20) @(negedge clk);
        check("idle_busy",  32'(o_busy),      32'h0);
        check("idle_valid", 32'(o_res_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
